apb_sram_ctrl: RTL and testbench

APB3 completer that turns APB read/write transfers into single-port SRAM accesses. It sits between the APB interconnect and one synchronous single-port SRAM with 1-cycle read latency. The SRAM drives dout on the cycle after en=1, we=0 and writes on the en=1, we=1 edge. The block decodes word addresses, flags illegal accesses with PSLVERR, and inserts the wait states the SRAM read latency requires.

---
 rtl/apb_sram_ctrl.sv | 145 ++++++++++++++
 tb/tb_apb_sram_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_sram_ctrl.sv
// APB3 completer bridging APB transfers onto a synchronous single-port SRAM
// with one cycle of read latency. Misaligned and out-of-range accesses get PSLVERR.
module apb_sram_ctrl #(
   parameter int unsigned addr_bits   = 10,
   parameter int unsigned data_width  = 32,
   parameter int unsigned paddr_width = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [paddr_width-1:0] paddr,
   input  logic [data_width-1:0]  pwdata,
   output logic                   pready,
   output logic [data_width-1:0]  prdata,
   output logic                   pslverr,
   output logic                   sram_en,
   output logic                   sram_we,
   output logic [addr_bits-1:0]   sram_addr,
   output logic [data_width-1:0]  sram_din,
   input  logic [data_width-1:0]  sram_dout
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StWr      = 3'd1;
   localparam logic [2:0] StRdIssue = 3'd2;
   localparam logic [2:0] StRdWait  = 3'd3;
   localparam logic [2:0] StRdResp  = 3'd4;
   localparam logic [2:0] StErr     = 3'd5;

   localparam int unsigned HiShift = addr_bits + 2;

   logic [2:0]            state_q, state_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [data_width-1:0] prdata_q, prdata_d;
   logic                  sram_en_q, sram_en_d;
   logic                  sram_we_q, sram_we_d;
   logic [addr_bits-1:0]  sram_addr_q, sram_addr_d;
   logic [data_width-1:0] sram_din_q, sram_din_d;

   logic                  setup;
   logic                  addr_err;
   logic                  xfer_end;
   logic [addr_bits-1:0]  word_addr;

   assign word_addr = paddr[addr_bits+1:2];
   // Shift rather than slice so the range check stays legal when no upper bits exist.
   assign addr_err  = (paddr[1:0] != 2'b00) || ((paddr >> HiShift) != '0);
   assign setup     = psel && !penable;
   // Both a normal completion and an abort (psel dropped) end the transfer.
   assign xfer_end  = !psel || (penable && pready_q);

   always_comb begin
      state_d     = state_q;
      pready_d    = pready_q;
      pslverr_d   = pslverr_q;
      prdata_d    = prdata_q;
      sram_en_d   = 1'b0;
      sram_we_d   = 1'b0;
      sram_addr_d = sram_addr_q;
      sram_din_d  = sram_din_q;

      case (state_q)
         StIdle: begin
            if (setup) begin
               if (addr_err) begin
                  state_d   = StErr;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else if (pwrite) begin
                  state_d     = StWr;
                  sram_en_d   = 1'b1;
                  sram_we_d   = 1'b1;
                  sram_addr_d = word_addr;
                  sram_din_d  = pwdata;
                  pready_d    = 1'b1;
               end else begin
                  state_d     = StRdIssue;
                  sram_en_d   = 1'b1;
                  sram_addr_d = word_addr;
               end
            end
         end
         StWr, StErr, StRdResp: begin
            if (xfer_end) begin
               state_d   = StIdle;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
         end
         StRdIssue: begin
            state_d = psel ? StRdWait : StIdle;
         end
         StRdWait: begin
            if (!psel) begin
               state_d = StIdle;
            end else begin
               state_d  = StRdResp;
               prdata_d = sram_dout;
               pready_d = 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
         sram_en_q   <= 1'b0;
         sram_we_q   <= 1'b0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
      end else begin
         state_q     <= state_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         prdata_q    <= prdata_d;
         sram_en_q   <= sram_en_d;
         sram_we_q   <= sram_we_d;
         sram_addr_q <= sram_addr_d;
         sram_din_q  <= sram_din_d;
      end
   end

   assign pready    = pready_q;
   assign pslverr   = pslverr_q;
   assign prdata    = prdata_q;
   assign sram_en   = sram_en_q;
   assign sram_we   = sram_we_q;
   assign sram_addr = sram_addr_q;
   assign sram_din  = sram_din_q;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Scoreboard bench for apb_sram_ctrl: APB transfers push expected responses,
// completions pop and compare them. A behavioural SRAM answers the DUT.
module tb_apb_sram_ctrl;

   localparam int AB = 10;
   localparam int DW = 32;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          psel, penable, pwrite;
   logic [PW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready, pslverr;
   logic [DW-1:0] prdata;
   logic          sram_en, sram_we;
   logic [AB-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout;

   always #5 clk = ~clk;

   apb_sram_ctrl #(
      .addr_bits  (AB),
      .data_width (DW),
      .paddr_width(PW)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pready   (pready),
      .prdata   (prdata),
      .pslverr  (pslverr),
      .sram_en  (sram_en),
      .sram_we  (sram_we),
      .sram_addr(sram_addr),
      .sram_din (sram_din),
      .sram_dout(sram_dout)
   );

   logic [DW-1:0] mem [1<<AB];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) mem[sram_addr] <= sram_din;
         else         sram_dout      <= mem[sram_addr];
      end
   end

   typedef struct {
      logic          err;
      logic [DW-1:0] data;
      int            waits;
      int            ens;
      logic          we;
      logic [AB-1:0] addr;
      logic [DW-1:0] din;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] ref_mem [1<<AB];
   int            n_vec = 0;
   int            n_err = 0;
   int            run_viol = 0;
   int            we_viol = 0;
   logic          prev_en = 1'b0;

   always @(negedge clk) begin
      if (prev_en && sram_en) run_viol++;
      if (sram_we && !sram_en) we_viol++;
      prev_en = sram_en;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the completion edge with psel low.
   task automatic apb_xfer(input logic wr, input logic [PW-1:0] addr, input logic [DW-1:0] wdata);
      exp_t          e;
      exp_t          got;
      logic          done;
      int            waits;
      int            en_cnt;
      logic          cap_we;
      logic [AB-1:0] cap_addr;
      logic [DW-1:0] cap_din;
      logic          obs_err;
      logic [DW-1:0] obs_data;
      e.err   = (addr[1:0] != 2'b00) || (addr >= PW'(4 << AB));
      e.addr  = addr[AB+1:2];
      e.we    = wr;
      e.din   = wdata;
      e.ens   = e.err ? 0 : 1;
      e.waits = (e.err || wr) ? 0 : 2;
      e.data  = (e.err || wr) ? '0 : ref_mem[e.addr];
      if (!e.err && wr) ref_mem[e.addr] = wdata;
      sb_q.push_back(e);

      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      done = 1'b0; waits = 0; en_cnt = 0;
      cap_we = 1'b0; cap_addr = '0; cap_din = '0; obs_err = 1'b0; obs_data = '0;
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         if (sram_en) begin
            en_cnt++;
            cap_we = sram_we; cap_addr = sram_addr; cap_din = sram_din;
         end
         if (pready) begin
            done = 1'b1; obs_err = pslverr; obs_data = prdata;
         end else begin
            waits++;
            @(posedge clk); #1;
         end
      end
      got = sb_q.pop_front();
      check_eq("pready_seen", 64'(done), 64'd1);
      if (done) begin
         check_eq("pslverr", 64'(obs_err), 64'(got.err));
         check_eq("prdata", 64'(obs_data), 64'(got.data));
         check_eq("wait_states", 64'(waits), 64'(got.waits));
      end
      check_eq("sram_en_pulses", 64'(en_cnt), 64'(got.ens));
      if (got.ens == 1 && en_cnt == 1) begin
         check_eq("sram_we", 64'(cap_we), 64'(got.we));
         check_eq("sram_addr", 64'(cap_addr), 64'(got.addr));
         if (got.we) check_eq("sram_din", 64'(cap_din), 64'(got.din));
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      #3;
      check_eq("rst_pready", 64'(pready), 64'd0);
      check_eq("rst_pslverr", 64'(pslverr), 64'd0);
      check_eq("rst_prdata", 64'(prdata), 64'd0);
      check_eq("rst_sram_en", 64'(sram_en), 64'd0);
      check_eq("rst_sram_addr", 64'(sram_addr), 64'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      apb_xfer(1'b1, 32'h10, 32'hDEADBEEF);
      apb_xfer(1'b0, 32'h10, 32'h0);

      // Back-to-back: each call starts its setup phase right after the previous completion.
      for (int i = 0; i < 3; i++) apb_xfer(1'b1, 32'(4 * i), 32'(i + 1));
      for (int i = 0; i < 3; i++) apb_xfer(1'b0, 32'(4 * i), 32'h0);

      apb_xfer(1'b1, 32'h6, 32'h55AA55AA);
      apb_xfer(1'b0, 32'h6, 32'h0);
      apb_xfer(1'b0, 32'h4, 32'h0);

      apb_xfer(1'b1, 32'h1000, 32'hBAD0BAD0);
      apb_xfer(1'b1, 32'hFFC, 32'hCAFEF00D);
      apb_xfer(1'b0, 32'hFFC, 32'h0);
      apb_xfer(1'b0, 32'h1000, 32'h0);

      // Abort a read in the wait state.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
      @(posedge clk); #1; penable = 1'b1;
      @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("abort_pready", 64'(pready), 64'd0);
         check_eq("abort_prdata", 64'(prdata), 64'd0);
      end
      @(posedge clk); #1;
      apb_xfer(1'b1, 32'h20, 32'h12345678);
      apb_xfer(1'b0, 32'h20, 32'h0);

      // Asynchronous reset while the read is being issued.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
      @(posedge clk); #1; penable = 1'b1;
      #2; rstn = 1'b0; #1;
      check_eq("arst_sram_en", 64'(sram_en), 64'd0);
      check_eq("arst_sram_addr", 64'(sram_addr), 64'd0);
      check_eq("arst_sram_din", 64'(sram_din), 64'd0);
      check_eq("arst_pready", 64'(pready), 64'd0);
      check_eq("arst_prdata", 64'(prdata), 64'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      apb_xfer(1'b0, 32'h10, 32'h0);
      apb_xfer(1'b0, 32'h8, 32'h0);

      check_eq("sram_en_run", 64'(run_viol), 64'd0);
      check_eq("sram_we_alone", 64'(we_viol), 64'd0);
      check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
